load_store_unit: RTL and testbench

Sits between the processor datapath and the data `async_memory`, converting processor load/store requests into memory accesses. Aligned accesses complete in one memory cycle. Misaligned halfword and word accesses are split into a sequence of aligned accesses: two word reads for a load, byte writes for a store. Load data is lane-extracted and sign- or zero-extended before it is returned with a one-cycle response pulse.

---
 rtl/lsu_pkg.sv | 25 ++
 rtl/load_align.sv | 27 ++
 rtl/load_store_unit.sv | 175 +++++++++++++++++
 tb/tb_load_store_unit.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared size codes, FSM state encoding and size helper for the load/store unit.
package lsu_pkg;

   localparam logic [1:0] SZ_BYTE = 2'd0;
   localparam logic [1:0] SZ_HALF = 2'd1;
   localparam logic [1:0] SZ_UNAL = 2'd2;
   localparam logic [1:0] SZ_WORD = 3'd3;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      LD_HI    = 2'd1,
      ST_BYTES = 2'd2
   } state_t;

   // Access width in bytes; the illegal code reports zero.
   function automatic logic [2:0] size_bytes(input logic [1:0] size);
      case (size)
         SZ_BYTE: size_bytes = 3'd1;
         SZ_HALF: size_bytes = 3'd2;
         SZ_WORD: size_bytes = 3'd4;
         default: size_bytes = 3'd0;
      endcase
   endfunction

endpackage

// File: rtl/load_align.sv
// Lane extraction and sign/zero extension of load data taken from a {hi, lo} word pair.
module load_align
   import lsu_pkg::*;
(
   input  logic [63:0] data,
   input  logic [1:0]  off,
   input  logic [1:0]  size,
   input  logic        sgn,
   output logic [31:0] result
);

   logic [31:0]        shifted;
   logic signed [7:0]  byte_s;
   logic signed [15:0] half_s;

   always_comb begin
      shifted = 32'(data >> {off, 3'b000});
      byte_s  = shifted[7:0];
      half_s  = shifted[15:0];
      case (size)
         SZ_BYTE: result = sgn ? 32'(byte_s) : {24'd0, shifted[7:0]};
         SZ_HALF: result = sgn ? 32'(half_s) : {16'd0, shifted[15:0]};
         default: result = shifted;
      endcase
   end

endmodule

// File: rtl/load_store_unit.sv
// Converts processor load/store requests into aligned memory accesses, splitting
// misaligned loads into two word reads and misaligned stores into byte writes.
module load_store_unit
   import lsu_pkg::*;
#(
   parameter int SPLIT_MISALIGNED = 1
)
(
   input  logic        clock,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [1:0]  req_size,
   input  logic        req_signed,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        resp_valid,
   output logic [31:0] resp_rdata,
   output logic        resp_err,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   output logic [1:0]  mem_size,
   output logic        mem_we,
   output logic        mem_re,
   input  logic [31:0] mem_rdata
);

   state_t      state, state_next;
   logic [31:0] addr_r, wdata_r, lo_r;
   logic [1:0]  size_r;
   logic        sgn_r;
   logic [1:0]  idx;
   logic [2:0]  n_m1;
   logic        last_byte;

   logic        misaligned, reject, split;

   logic [63:0] al_data;
   logic [1:0]  al_off, al_size;
   logic        al_sgn;
   logic [31:0] al_result;

   logic        resp_vld_p1, resp_err_p1;
   logic [31:0] resp_rdata_p1;

   assign req_ready  = (state == IDLE) && !reset;
   assign misaligned = ((req_size == SZ_HALF) && req_addr[0]) ||
                       ((req_size == SZ_WORD) && (req_addr[1:0] != 2'b00));
   assign reject     = (req_size == SZ_UNAL) || (misaligned && (SPLIT_MISALIGNED == 0));
   assign split      = misaligned && !reject;
   assign n_m1       = size_bytes(size_r) - 3'd1;
   assign last_byte  = ({1'b0, idx} == n_m1);

   load_align u_align (
      .data   (al_data),
      .off    (al_off),
      .size   (al_size),
      .sgn    (al_sgn),
      .result (al_result)
   );

   // In IDLE the memory sees the live request; afterwards it sees the captured copy.
   always_comb begin
      state_next = state;
      mem_addr   = '0;
      mem_wdata  = '0;
      mem_size   = SZ_WORD;
      mem_we     = 1'b0;
      mem_re     = 1'b0;
      al_data    = {32'd0, mem_rdata};
      al_off     = req_addr[1:0];
      al_size    = req_size;
      al_sgn     = req_signed;
      if (!reset) begin
         case (state)
            IDLE: begin
               if (req_valid && !reject) begin
                  if (split && req_we) begin
                     mem_we     = 1'b1;
                     mem_addr   = req_addr;
                     mem_size   = SZ_BYTE;
                     mem_wdata  = {24'd0, req_wdata[7:0]};
                     state_next = ST_BYTES;
                  end else if (split) begin
                     mem_re     = 1'b1;
                     mem_addr   = {req_addr[31:2], 2'b00};
                     mem_size   = SZ_WORD;
                     state_next = LD_HI;
                  end else begin
                     mem_we    = req_we;
                     mem_re    = !req_we;
                     mem_addr  = req_addr;
                     mem_size  = req_size;
                     mem_wdata = req_wdata;
                  end
               end
            end
            LD_HI: begin
               mem_re     = 1'b1;
               mem_addr   = {addr_r[31:2], 2'b00} + 32'd4;
               mem_size   = SZ_WORD;
               al_data    = {mem_rdata, lo_r};
               al_off     = addr_r[1:0];
               al_size    = size_r;
               al_sgn     = sgn_r;
               state_next = IDLE;
            end
            ST_BYTES: begin
               mem_we    = 1'b1;
               mem_addr  = addr_r + {30'd0, idx};
               mem_size  = SZ_BYTE;
               mem_wdata = {24'd0, wdata_r[{idx, 3'b000} +: 8]};
               if (last_byte) state_next = IDLE;
            end
            default: state_next = IDLE;
         endcase
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state         <= IDLE;
         idx           <= 2'd0;
         resp_vld_p1   <= 1'b0;
         resp_err_p1   <= 1'b0;
         resp_rdata_p1 <= '0;
      end else begin
         state         <= state_next;
         resp_vld_p1   <= 1'b0;
         resp_err_p1   <= 1'b0;
         resp_rdata_p1 <= '0;
         case (state)
            IDLE: begin
               if (req_valid) begin
                  if (reject) begin
                     resp_vld_p1 <= 1'b1;
                     resp_err_p1 <= 1'b1;
                  end else if (split) begin
                     idx <= 2'd1;
                  end else begin
                     resp_vld_p1 <= 1'b1;
                     if (!req_we) resp_rdata_p1 <= al_result;
                  end
               end
            end
            LD_HI: begin
               resp_vld_p1   <= 1'b1;
               resp_rdata_p1 <= al_result;
            end
            ST_BYTES: begin
               idx <= idx + 2'd1;
               if (last_byte) resp_vld_p1 <= 1'b1;
            end
            default: ;
         endcase
      end
   end

   // Request capture; the low word of a split load is held for the LD_HI cycle.
   always_ff @(posedge clock) begin
      if (state == IDLE && req_valid) begin
         addr_r  <= req_addr;
         wdata_r <= req_wdata;
         size_r  <= req_size;
         sgn_r   <= req_signed;
         lo_r    <= mem_rdata;
      end
   end

   assign resp_valid = resp_vld_p1;
   assign resp_err   = resp_err_p1;
   assign resp_rdata = resp_rdata_p1;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a small word-array memory model.
module tb_load_store_unit;
   import lsu_pkg::*;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        req_valid = 1'b0, req_we = 1'b0, req_signed = 1'b0;
   logic [1:0]  req_size = 2'd0;
   logic [31:0] req_addr = '0, req_wdata = '0;
   logic        req_ready, resp_valid, resp_err, mem_we, mem_re;
   logic [31:0] resp_rdata, mem_addr, mem_wdata;
   logic [1:0]  mem_size;
   logic [31:0] mem_rdata = '0;

   logic        r_req_valid = 1'b0, r_req_we = 1'b0, r_req_signed = 1'b0;
   logic [1:0]  r_req_size = 2'd0;
   logic [31:0] r_req_addr = '0, r_req_wdata = '0;
   logic        r_req_ready, r_resp_valid, r_resp_err, r_mem_we, r_mem_re;
   logic [31:0] r_resp_rdata, r_mem_addr, r_mem_wdata;
   logic [1:0]  r_mem_size;
   logic [31:0] r_mem_rdata = '0;

   logic [31:0] mem_words [0:63];
   logic [31:0] acc_addr [0:63];
   int          acc_n = 0;
   int          checks = 0, passes = 0;
   int          a0;

   always #5 clock = ~clock;

   load_store_unit #(.SPLIT_MISALIGNED(1)) dut (
      .clock(clock), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
      .req_we(req_we), .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
      .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
      .resp_err(resp_err), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_size(mem_size),
      .mem_we(mem_we), .mem_re(mem_re), .mem_rdata(mem_rdata)
   );

   load_store_unit #(.SPLIT_MISALIGNED(0)) dut_rej (
      .clock(clock), .reset(reset), .req_valid(r_req_valid), .req_ready(r_req_ready),
      .req_we(r_req_we), .req_size(r_req_size), .req_signed(r_req_signed), .req_addr(r_req_addr),
      .req_wdata(r_req_wdata), .resp_valid(r_resp_valid), .resp_rdata(r_resp_rdata),
      .resp_err(r_resp_err), .mem_addr(r_mem_addr), .mem_wdata(r_mem_wdata), .mem_size(r_mem_size),
      .mem_we(r_mem_we), .mem_re(r_mem_re), .mem_rdata(r_mem_rdata)
   );

   // Memory model: writes commit on posedge, reads return the containing word on negedge.
   always @(posedge clock) begin
      if (mem_we) begin
         case (mem_size)
            SZ_BYTE: mem_words[mem_addr[7:2]][{mem_addr[1:0], 3'b000} +: 8] <= mem_wdata[7:0];
            SZ_HALF: mem_words[mem_addr[7:2]][{mem_addr[1], 4'b0000} +: 16] <= mem_wdata[15:0];
            default: mem_words[mem_addr[7:2]] <= mem_wdata;
         endcase
      end
      if (mem_we || mem_re) begin
         acc_addr[acc_n[5:0]] <= mem_addr;
         acc_n <= acc_n + 1;
      end
   end

   always @(negedge clock) mem_rdata <= mem_words[mem_addr[7:2]];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) passes++;
      else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
   endtask

   task automatic send(input logic we, input logic [1:0] size, input logic sgn,
                       input logic [31:0] addr, input logic [31:0] wdata);
      req_we = we; req_size = size; req_signed = sgn; req_addr = addr; req_wdata = wdata;
      req_valid = 1'b1;
      @(posedge clock); #1;
      req_valid = 1'b0;
      req_addr  = 32'hFFFF_FFFF;
      req_wdata = 32'h5A5A_5A5A;
      req_size  = SZ_BYTE;
   endtask

   task automatic wait_resp(input string tag, input int exp_lat,
                            input logic [31:0] exp_rdata, input logic exp_err);
      int lat = 1;
      while (!resp_valid && lat < 10) begin
         @(posedge clock); #1;
         lat++;
      end
      check({tag, ".latency"}, lat, exp_lat);
      check({tag, ".rdata"}, resp_rdata, exp_rdata);
      check({tag, ".err"}, {31'd0, resp_err}, {31'd0, exp_err});
   endtask

   task automatic store_word(input logic [31:0] addr, input logic [31:0] data);
      send(1'b1, SZ_WORD, 1'b0, addr, data);
      wait_resp("preload", 1, 32'd0, 1'b0);
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end

   initial begin
      repeat (2) @(posedge clock);
      #1;
      check("rst.ready", {31'd0, req_ready}, 32'd0);
      check("rst.resp_valid", {31'd0, resp_valid}, 32'd0);
      check("rst.resp_rdata", resp_rdata, 32'd0);
      check("rst.mem_we_re", {30'd0, mem_we, mem_re}, 32'd0);
      check("rst.mem_size", {30'd0, mem_size}, 32'd3);
      check("rst.mem_addr", mem_addr, 32'd0);
      reset = 1'b0;
      #1;
      check("post_rst.ready", {31'd0, req_ready}, 32'd1);
      @(posedge clock); #1;

      // Aligned word store then load
      a0 = acc_n;
      send(1'b1, SZ_WORD, 1'b0, 32'h1000_0010, 32'hDEAD_BEEF);
      wait_resp("sw_aligned", 1, 32'd0, 1'b0);
      check("sw_aligned.accesses", acc_n - a0, 32'd1);
      check("sw_aligned.mem", mem_words[4], 32'hDEAD_BEEF);
      a0 = acc_n;
      send(1'b0, SZ_WORD, 1'b0, 32'h1000_0010, 32'd0);
      wait_resp("lw_aligned", 1, 32'hDEAD_BEEF, 1'b0);
      check("lw_aligned.accesses", acc_n - a0, 32'd1);

      // Byte and halfword extension
      store_word(32'h1000_0020, 32'h80FF_7F01);
      send(1'b0, SZ_BYTE, 1'b1, 32'h1000_0022, 32'd0);
      wait_resp("lb_signed", 1, 32'hFFFF_FFFF, 1'b0);
      send(1'b0, SZ_BYTE, 1'b0, 32'h1000_0023, 32'd0);
      wait_resp("lbu", 1, 32'h0000_0080, 1'b0);
      send(1'b0, SZ_HALF, 1'b1, 32'h1000_0022, 32'd0);
      wait_resp("lh_signed", 1, 32'hFFFF_80FF, 1'b0);

      // Misaligned loads
      store_word(32'h1000_0030, 32'h4433_2211);
      store_word(32'h1000_0034, 32'h8877_6655);
      a0 = acc_n;
      send(1'b0, SZ_WORD, 1'b0, 32'h1000_0031, 32'd0);
      wait_resp("lw_mis", 2, 32'h5544_3322, 1'b0);
      check("lw_mis.accesses", acc_n - a0, 32'd2);
      check("lw_mis.addr0", acc_addr[a0[5:0]], 32'h1000_0030);
      check("lw_mis.addr1", acc_addr[6'(a0 + 1)], 32'h1000_0034);
      send(1'b0, SZ_HALF, 1'b0, 32'h1000_0033, 32'd0);
      wait_resp("lhu_mis", 2, 32'h0000_5544, 1'b0);

      // Misaligned load across the 32-bit address wrap
      store_word(32'hFFFF_FFFC, 32'hCAFE_F00D);
      store_word(32'h0000_0000, 32'h0BAD_BEEF);
      a0 = acc_n;
      send(1'b0, SZ_WORD, 1'b0, 32'hFFFF_FFFE, 32'd0);
      wait_resp("lw_wrap", 2, 32'hBEEF_CAFE, 1'b0);
      check("lw_wrap.addr1", acc_addr[6'(a0 + 1)], 32'h0000_0000);

      // Misaligned word store as four byte writes
      store_word(32'h1000_0040, 32'hADAD_ADAD);
      store_word(32'h1000_0044, 32'hADAD_ADAD);
      a0 = acc_n;
      send(1'b1, SZ_WORD, 1'b0, 32'h1000_0042, 32'hA1B2_C3D4);
      wait_resp("sw_mis", 4, 32'd0, 1'b0);
      check("sw_mis.accesses", acc_n - a0, 32'd4);
      for (int i = 0; i < 4; i++)
         check("sw_mis.addr", acc_addr[6'(a0 + i)], 32'h1000_0042 + 32'(i));
      check("sw_mis.word40", mem_words[16], 32'hC3D4_ADAD);
      check("sw_mis.word44", mem_words[17], 32'hADAD_A1B2);
      send(1'b0, SZ_WORD, 1'b0, 32'h1000_0040, 32'd0);
      wait_resp("lw_after_sw_mis", 1, 32'hC3D4_ADAD, 1'b0);

      // Illegal size
      a0 = acc_n;
      send(1'b1, SZ_UNAL, 1'b0, 32'h1000_0050, 32'h1234_5678);
      wait_resp("illegal_store", 1, 32'd0, 1'b1);
      send(1'b0, SZ_UNAL, 1'b1, 32'h1000_0050, 32'd0);
      wait_resp("illegal_load", 1, 32'd0, 1'b1);
      check("illegal.accesses", acc_n - a0, 32'd0);

      // Non-splitting instance rejects misaligned halfword, accepts aligned word
      r_req_we = 1'b0; r_req_size = SZ_HALF; r_req_signed = 1'b0; r_req_addr = 32'h1000_0001;
      r_req_valid = 1'b1;
      #1;
      check("rej.mem_we_re", {30'd0, r_mem_we, r_mem_re}, 32'd0);
      @(posedge clock); #1;
      r_req_valid = 1'b0;
      check("rej.resp_valid", {31'd0, r_resp_valid}, 32'd1);
      check("rej.resp_err", {31'd0, r_resp_err}, 32'd1);
      check("rej.resp_rdata", r_resp_rdata, 32'd0);
      r_req_size = SZ_WORD; r_req_addr = 32'h1000_0004;
      r_req_valid = 1'b1;
      @(posedge clock); #1;
      r_req_valid = 1'b0;
      check("rej_aligned.resp_valid", {31'd0, r_resp_valid}, 32'd1);
      check("rej_aligned.resp_err", {31'd0, r_resp_err}, 32'd0);

      // Reset during ST_BYTES after two byte writes
      store_word(32'h1000_0060, 32'hADAD_ADAD);
      store_word(32'h1000_0064, 32'hADAD_ADAD);
      a0 = acc_n;
      send(1'b1, SZ_WORD, 1'b0, 32'h1000_0061, 32'h1122_3344);
      check("rst_mid.busy", {31'd0, req_ready}, 32'd0);
      @(posedge clock); #1;
      check("rst_mid.writes_before", acc_n - a0, 32'd2);
      reset = 1'b1;
      @(posedge clock); #1;
      check("rst_mid.resp_in_reset", {31'd0, resp_valid}, 32'd0);
      reset = 1'b0;
      #1;
      check("rst_mid.ready", {31'd0, req_ready}, 32'd1);
      @(posedge clock); #1;
      check("rst_mid.resp_after", {31'd0, resp_valid}, 32'd0);
      check("rst_mid.writes_total", acc_n - a0, 32'd2);
      check("rst_mid.word60", mem_words[24], 32'hAD33_44AD);
      check("rst_mid.word64", mem_words[25], 32'hADAD_ADAD);
      send(1'b0, SZ_WORD, 1'b0, 32'h1000_0060, 32'd0);
      wait_resp("lw_after_rst", 1, 32'hAD33_44AD, 1'b0);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
